// File: rtl/apb_master_pkg.sv
// Shared types for apb_master: transfer FSM states and output reset values.
// Data/address buses reset to all-zeros at their point of use.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic RST_REQ_READY  = 1'b1;
  localparam logic RST_RSP_VALID  = 1'b0;
  localparam logic RST_RSP_ERR    = 1'b0;
  localparam logic RST_APB_SEL    = 1'b0;
  localparam logic RST_APB_ENABLE = 1'b0;
  localparam logic RST_APB_WR     = 1'b0;

endpackage

// File: rtl/apb_watchdog.sv
// Access-phase watchdog, present only with APB_MASTER_TIMEOUT_EN; expire is combinational and
// fires on the TIMEOUT_CYCLES-th consecutive not-ready access cycle.
`ifdef APB_MASTER_TIMEOUT_EN
module apb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  // The edge that would bring the count to TIMEOUT_CYCLES is the expiry edge.
  assign expire = inc && (count == LAST);

endmodule
`endif

// File: rtl/apb_master.sv
// APB-style requester: one command in flight, setup+access per transfer, registered outputs.
// Optional access timeout under APB_MASTER_TIMEOUT_EN; otherwise ACCESS waits for apb_ready forever.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 32,
  parameter int ADDR_WIDTH     = $clog2(DEPTH),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  apb_sel,
  output logic                  apb_enable,
  output logic                  apb_wr,
  output logic [ADDR_WIDTH-1:0] apb_addr,
  output logic [DATA_WIDTH-1:0] apb_wdata,
  input  logic                  apb_ready,
  input  logic [DATA_WIDTH-1:0] apb_rdata
);

  state_t state, state_nxt;
  logic   accept;
  logic   done;
  logic   timeout;

  assign accept = (state == IDLE) && req_valid;
  assign done   = (state == ACCESS) && apb_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == SETUP),
    .inc    ((state == ACCESS) && !apb_ready),
    .expire (timeout)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (apb_ready || timeout) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready  <= RST_REQ_READY;
      rsp_valid  <= RST_RSP_VALID;
      apb_sel    <= RST_APB_SEL;
      apb_enable <= RST_APB_ENABLE;
      apb_wr     <= RST_APB_WR;
      apb_addr   <= '0;
      apb_wdata  <= '0;
      rsp_rdata  <= '0;
    end else begin
      req_ready  <= (state_nxt == IDLE);
      rsp_valid  <= (state_nxt == RESP);
      apb_sel    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      apb_enable <= (state_nxt == ACCESS);
      if (accept) begin
        apb_wr    <= req_wr;
        apb_addr  <= req_addr;
        apb_wdata <= req_wdata;
      end
      if (done) begin
        rsp_rdata <= apb_wr ? '0 : apb_rdata;
      end else if (timeout) begin
        rsp_rdata <= '0;
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_err <= RST_RSP_ERR;
    end else if (done) begin
      rsp_err <= 1'b0;
    end else if (timeout) begin
      rsp_err <= 1'b1;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  assert property (@(posedge clk) disable iff (reset) !(rsp_valid && req_ready));
  assert property (@(posedge clk) disable iff (reset) apb_enable |-> apb_sel);

endmodule
